// File: rtl/dq_train_pkg.sv
// Shared types and constants for the DQ read-training sequencer.
// Optional build macro: DQ_TRAIN_TIMEOUT_EN (read-starvation timeout).
package dq_train_pkg;

  localparam int TAP_W = 8;
  localparam logic [7:0] PATTERN_DEF = 8'h55;

  typedef logic [TAP_W-1:0] tap_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_CENTER,
    S_FIN_OK,
    S_FIN_FAIL
  } state_e;

endpackage

// File: rtl/dq_train_window_tracker.sv
// Passing-window bookkeeping: start/end/in_window, width qualification
// and the centre tap of the accepted window.
module dq_train_window_tracker
  import dq_train_pkg::*;
#(
  parameter int MIN_WINDOW = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic eval_i,
  input  logic pass_i,
  input  tap_t tap_i,
  output tap_t start_o,
  output tap_t end_o,
  output tap_t target_o,
  output logic in_win_o,
  output logic win_ok_o
);

  localparam logic [TAP_W:0] MIN_W = (TAP_W+1)'(MIN_WINDOW);

  tap_t start_q;
  tap_t end_q;
  logic in_win_q;

  tap_t cur_start;
  logic [TAP_W:0] w_pass;
  logic [TAP_W:0] w_hold;

  // Widths are one bit wider so a full 256-tap window does not wrap.
  always_comb begin
    cur_start = in_win_q ? start_q : tap_i;
    w_pass = {1'b0, tap_i} - {1'b0, cur_start} + 9'd1;
    w_hold = {1'b0, end_q} - {1'b0, start_q} + 9'd1;
    win_ok_o = pass_i ? (w_pass >= MIN_W)
                      : (in_win_q && (w_hold >= MIN_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q <= '0;
      in_win_q <= 1'b0;
    end else if (clear_i) begin
      start_q <= '0;
      end_q <= '0;
      in_win_q <= 1'b0;
    end else if (eval_i) begin
      if (pass_i) begin
        start_q <= cur_start;
        end_q <= tap_i;
        in_win_q <= 1'b1;
      end else if (in_win_q && !win_ok_o) begin
        in_win_q <= 1'b0;
      end
    end
  end

  assign start_o = start_q;
  assign end_o = end_q;
  assign in_win_o = in_win_q;
  assign target_o = start_q + ((end_q - start_q) >> 1);

endmodule

// File: rtl/dq_read_train_ctrl.sv
// Per-lane DQ read-training sequencer driving the IOD delay line.
// Optional build macro: DQ_TRAIN_TIMEOUT_EN (fail on read starvation).
module dq_read_train_ctrl
  import dq_train_pkg::*;
#(
  parameter int NUM_TAPS = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES_PER_TAP = 4,
  parameter int MIN_WINDOW = 8,
  parameter logic [7:0] PATTERN = PATTERN_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic FAB_CLK,
  input  logic ARST_N,
  input  logic START,
  input  logic DDR_DO_READ,
  input  logic [7:0] RX_DATA,
  input  logic EYE_MONITOR_EARLY,
  input  logic EYE_MONITOR_LATE,
  input  logic DELAY_LINE_OUT_OF_RANGE,
  output logic DELAY_LINE_LOAD,
  output logic DELAY_LINE_MOVE,
  output logic DELAY_LINE_DIRECTION,
  output logic EYE_MONITOR_CLEAR_FLAGS,
  output logic [7:0] TAP_VALUE,
  output logic [7:0] WINDOW_START,
  output logic [7:0] WINDOW_END,
  output logic BUSY,
  output logic DONE,
  output logic FAIL
);

  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SMP_LAST = 16'(SAMPLES_PER_TAP - 1);
  localparam tap_t LAST_TAP = tap_t'(NUM_TAPS - 1);

  state_e state_q, state_d;
  tap_t tap_q, tap_d;
  logic [15:0] set_cnt_q, set_cnt_d;
  logic [15:0] smp_cnt_q, smp_cnt_d;
  logic bad_q, bad_d;
  logic gap_q, gap_d;
`ifdef DQ_TRAIN_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  logic trk_clear, trk_eval;
  logic in_win, win_ok, pass, beat_bad;
  tap_t target;

  assign pass = !bad_q;
  assign beat_bad = (RX_DATA != PATTERN) || EYE_MONITOR_EARLY
                 || EYE_MONITOR_LATE;

  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    set_cnt_d = set_cnt_q;
    smp_cnt_d = smp_cnt_q;
    bad_d = bad_q;
    gap_d = gap_q;
`ifdef DQ_TRAIN_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    trk_clear = 1'b0;
    trk_eval = 1'b0;
    DELAY_LINE_LOAD = 1'b0;
    DELAY_LINE_MOVE = 1'b0;
    DELAY_LINE_DIRECTION = 1'b0;
    EYE_MONITOR_CLEAR_FLAGS = 1'b0;
    unique case (state_q)
      S_IDLE, S_FIN_OK, S_FIN_FAIL: begin
        if (START) begin
          state_d = S_LOAD;
          tap_d = '0;
          trk_clear = 1'b1;
        end
      end
      S_LOAD: begin
        DELAY_LINE_LOAD = 1'b1;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        EYE_MONITOR_CLEAR_FLAGS = 1'b1;
        smp_cnt_d = '0;
        set_cnt_d = '0;
        bad_d = 1'b0;
`ifdef DQ_TRAIN_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_cnt_q == SET_LAST) state_d = S_SAMPLE;
        else set_cnt_d = set_cnt_q + 16'd1;
      end
      S_SAMPLE: begin
        if (DDR_DO_READ) begin
          smp_cnt_d = smp_cnt_q + 16'd1;
          bad_d = bad_q | beat_bad;
          if (smp_cnt_q == SMP_LAST) state_d = S_EVAL;
        end
`ifdef DQ_TRAIN_TIMEOUT_EN
        if (DDR_DO_READ) to_cnt_d = '0;
        else if (to_cnt_q == TO_LAST) state_d = S_FIN_FAIL;
        else to_cnt_d = to_cnt_q + 16'd1;
`endif
      end
      S_EVAL: begin
        trk_eval = 1'b1;
        gap_d = 1'b0;
        // A closing window takes priority over the sweep-end check.
        if (!pass && in_win && win_ok) state_d = S_CENTER;
        else if (tap_q == LAST_TAP || DELAY_LINE_OUT_OF_RANGE)
          state_d = (pass && win_ok) ? S_CENTER : S_FIN_FAIL;
        else state_d = S_STEP;
      end
      S_STEP: begin
        DELAY_LINE_MOVE = 1'b1;
        DELAY_LINE_DIRECTION = 1'b1;
        tap_d = tap_q + 8'd1;
        state_d = S_CLEAR;
      end
      S_CENTER: begin
        if (tap_q <= target) begin
          state_d = S_FIN_OK;
        end else if (!gap_q) begin
          DELAY_LINE_MOVE = 1'b1;
          tap_d = tap_q - 8'd1;
          gap_d = 1'b1;
        end else begin
          gap_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= S_IDLE;
      tap_q <= '0;
      set_cnt_q <= '0;
      smp_cnt_q <= '0;
      bad_q <= 1'b0;
      gap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      set_cnt_q <= set_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      bad_q <= bad_d;
      gap_q <= gap_d;
    end
  end

`ifdef DQ_TRAIN_TIMEOUT_EN
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) to_cnt_q <= '0;
    else to_cnt_q <= to_cnt_d;
  end
`endif

  dq_train_window_tracker #(
    .MIN_WINDOW(MIN_WINDOW)
  ) u_trk (
    .clk     (FAB_CLK),
    .rst_n   (ARST_N),
    .clear_i (trk_clear),
    .eval_i  (trk_eval),
    .pass_i  (pass),
    .tap_i   (tap_q),
    .start_o (WINDOW_START),
    .end_o   (WINDOW_END),
    .target_o(target),
    .in_win_o(in_win),
    .win_ok_o(win_ok)
  );

  assign TAP_VALUE = tap_q;
  assign DONE = (state_q == S_FIN_OK);
  assign FAIL = (state_q == S_FIN_FAIL);
  assign BUSY = !(state_q == S_IDLE || DONE || FAIL);

endmodule

// File: tb/tb_dq_read_train_ctrl.sv
// Scoreboard bench for dq_read_train_ctrl with a behavioural IOD lane.
module tb_dq_read_train_ctrl;

  logic FAB_CLK = 1'b0;
  logic ARST_N = 1'b0;
  logic START = 1'b0;
  logic DDR_DO_READ = 1'b0;
  logic [7:0] RX_DATA = 8'h55;
  logic EYE_MONITOR_EARLY = 1'b0;
  logic EYE_MONITOR_LATE = 1'b0;
  logic DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic EYE_MONITOR_CLEAR_FLAGS;
  logic [7:0] TAP_VALUE, WINDOW_START, WINDOW_END;
  logic BUSY, DONE, FAIL;

  always #5 FAB_CLK = ~FAB_CLK;

  dq_read_train_ctrl dut (
    .FAB_CLK                (FAB_CLK),
    .ARST_N                 (ARST_N),
    .START                  (START),
    .DDR_DO_READ            (DDR_DO_READ),
    .RX_DATA                (RX_DATA),
    .EYE_MONITOR_EARLY      (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE       (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .TAP_VALUE              (TAP_VALUE),
    .WINDOW_START           (WINDOW_START),
    .WINDOW_END             (WINDOW_END),
    .BUSY                   (BUSY),
    .DONE                   (DONE),
    .FAIL                   (FAIL)
  );

  typedef struct {
    bit done;
    int ws;
    int we;
    int tap;
    int inc;
    int dec;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  bit [255:0] pmask = '0;
  int oor_tap = -1;
  bit starve = 1'b0;
  int mtap = 0;
  int n_load = 0, n_inc = 0, n_dec = 0, n_both = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // IOD lane model: follows LOAD/MOVE pulses, answers per tap.
  always @(negedge FAB_CLK) begin
    bit p;
    int mode;
    if (DELAY_LINE_LOAD) begin
      mtap = 0;
      n_load++;
    end
    if (DELAY_LINE_MOVE) begin
      if (DELAY_LINE_DIRECTION) begin
        mtap++;
        n_inc++;
      end else begin
        mtap--;
        n_dec++;
      end
    end
    if (DELAY_LINE_LOAD && DELAY_LINE_MOVE) n_both++;
    p = (mtap >= 0 && mtap < 256) ? pmask[mtap] : 1'b0;
    mode = (mtap < 0 ? 0 : mtap) % 3;
    DDR_DO_READ = starve ? 1'b0 : ($urandom_range(0, 3) != 0);
    RX_DATA = (!p && mode == 0) ? 8'h54 : 8'h55;
    EYE_MONITOR_EARLY = !p && mode == 1;
    EYE_MONITOR_LATE = !p && mode == 2;
    DELAY_LINE_OUT_OF_RANGE = (oor_tap >= 0) && (mtap >= oor_tap);
  end

  function automatic bit [255:0] rng(input int lo, input int hi);
    bit [255:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic exp_t predict(input bit [255:0] m, input int oor);
    exp_t e;
    bit inw = 1'b0;
    int s = 0, en = 0, t, tgt;
    e.done = 1'b0;
    for (t = 0; t < 128; t++) begin
      if (m[t]) begin
        if (!inw) begin
          s = t;
          inw = 1'b1;
        end
        en = t;
      end else if (inw) begin
        if (en - s + 1 >= 8) begin
          e.done = 1'b1;
          break;
        end
        inw = 1'b0;
      end
      if (t == 127 || t == oor) begin
        e.done = inw && (en - s + 1 >= 8);
        break;
      end
    end
    tgt = s + ((en - s) >> 1);
    e.ws = s;
    e.we = en;
    e.inc = t;
    e.tap = e.done ? tgt : t;
    e.dec = e.done ? t - tgt : 0;
    return e;
  endfunction

  task automatic run(input string nm, input bit [255:0] m, input int oor,
                     input bit extra_start);
    exp_t e;
    int cyc;
    pmask = m;
    oor_tap = oor;
    sb.push_back(predict(m, oor));
    n_load = 0; n_inc = 0; n_dec = 0; n_both = 0;
    @(negedge FAB_CLK) START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    check({nm, "_load1st"}, DELAY_LINE_LOAD, 1);
    check({nm, "_busy"}, BUSY, 1);
    if (extra_start) begin
      repeat (30) @(negedge FAB_CLK);
      START = 1'b1;
      @(negedge FAB_CLK) START = 1'b0;
    end
    cyc = 0;
    while (!(DONE || FAIL) && cyc < 20000) begin
      @(negedge FAB_CLK);
      cyc++;
    end
    check({nm, "_finish"}, int'(cyc < 20000), 1);
    e = sb.pop_front();
    check({nm, "_done"}, DONE, e.done);
    check({nm, "_fail"}, FAIL, !e.done);
    check({nm, "_idle"}, BUSY, 0);
    check({nm, "_tap"}, TAP_VALUE, e.tap);
    check({nm, "_inc"}, n_inc, e.inc);
    check({nm, "_dec"}, n_dec, e.dec);
    check({nm, "_loads"}, n_load, 1);
    check({nm, "_ldmv"}, n_both, 0);
    if (e.done) begin
      check({nm, "_ws"}, WINDOW_START, e.ws);
      check({nm, "_we"}, WINDOW_END, e.we);
    end
    repeat (3) @(negedge FAB_CLK);
    check({nm, "_hold"}, {DONE, FAIL}, {e.done, !e.done});
  endtask

  function automatic int outs();
    return int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                 EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, FAIL})
         | int'(TAP_VALUE) | int'(WINDOW_START) | int'(WINDOW_END);
  endfunction

  initial begin
    #12;
    check("rst_outs", outs(), 0);
    @(negedge FAB_CLK) ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    check("idle_outs", outs(), 0);

    run("win20_59", rng(20, 59), -1, 1'b0);
    run("glitch", rng(5, 8) | rng(30, 49), -1, 1'b1);
    run("nopass", '0, -1, 1'b0);
    run("lasttap", rng(100, 127), -1, 1'b0);
    run("oor50", rng(40, 127), 50, 1'b0);
    run("min8", rng(10, 17), -1, 1'b0);
    run("min7", rng(10, 16), -1, 1'b0);

    // Abort during the first settle period.
    pmask = rng(20, 59);
    oor_tap = -1;
    @(negedge FAB_CLK) START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    repeat (4) @(negedge FAB_CLK);
    check("pre_rst_busy", BUSY, 1);
    #2 ARST_N = 1'b0;
    #1 check("mid_rst_outs", outs(), 0);
    repeat (2) @(negedge FAB_CLK);
    n_load = 0; n_inc = 0; n_dec = 0;
    ARST_N = 1'b1;
    repeat (5) @(negedge FAB_CLK);
    check("post_rst_quiet", n_load + n_inc + n_dec, 0);
    check("post_rst_outs", outs(), 0);
    run("after_rst", rng(20, 59), -1, 1'b0);

`ifdef DQ_TRAIN_TIMEOUT_EN
    begin
      int cyc;
      starve = 1'b1;
      pmask = '1;
      @(negedge FAB_CLK) START = 1'b1;
      @(negedge FAB_CLK) START = 1'b0;
      cyc = 1;
      while (!FAIL && cyc < 3000) begin
        @(negedge FAB_CLK);
        cyc++;
      end
      check("timeout_cyc", cyc, 1035);
      starve = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
